// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl
// Purpose  : Parametrised interrupt controller. Captures NUM_SRC sources into
//            a sticky status register. Each source uses rising-edge or level
//            capture. The block supports write-1-to-clear, software set and a
//            per-source mask. It outputs a prioritised pending ID (bit 0
//            highest) and a CPU interrupt line in level or stretched-pulse mode.
// Ports    : clk            - clock, rising edge
//            reset_n_i      - synchronous reset, active low
//            intr_signal_i  - raw source inputs (strobes or levels)
//            intr_mask_i    - per-source enable, 1 = enabled
//            intr_clear_i   - write-1-to-clear strobe for status bits
//            intr_set_i     - software set strobe for status bits
//            intr_status_o  - sticky status (masked and unmasked)
//            intr_pending_o - registered status & mask
//            intr_valid_o   - any pending bit set
//            intr_id_o      - lowest-numbered pending bit, 0 when none
//            bus_intr_o     - CPU interrupt line
// Revision : 1.0 - initial release
// ============================================================================
module intr_ctrl #(
  parameter int                 NUM_SRC   = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}},
  parameter int                 OUT_MODE  = 1,
  parameter int                 PULSE_LEN = 1
) (
  input  logic                       clk,
  input  logic                       reset_n_i,
  input  logic [NUM_SRC-1:0]         intr_signal_i,
  input  logic [NUM_SRC-1:0]         intr_mask_i,
  input  logic [NUM_SRC-1:0]         intr_clear_i,
  input  logic [NUM_SRC-1:0]         intr_set_i,
  output logic [NUM_SRC-1:0]         intr_status_o,
  output logic [NUM_SRC-1:0]         intr_pending_o,
  output logic                       intr_valid_o,
  output logic [$clog2(NUM_SRC)-1:0] intr_id_o,
  output logic                       bus_intr_o
);

  localparam int ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] status_q,  status_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               valid_q;
  logic [ID_W-1:0]    id_q,      id_d;
  logic               bus_q;
  logic [NUM_SRC-1:0] evt;

  // Edge-mode bits fire only on a 0->1 transition. Level-mode bits fire every
  // cycle the input is high, so a clear does not stick while the input is high.
  assign evt       = (intr_signal_i & ~prev_q & EDGE_MASK) |
                     (intr_signal_i & ~EDGE_MASK);

  // Event and set win over clear, so a same-cycle event is never lost.
  assign status_d  = (status_q & ~intr_clear_i) | evt | intr_set_i;
  assign pending_d = status_d & intr_mask_i;

  // Fixed priority: scan from high to low so the lowest set bit wins.
  always_comb begin
    id_d = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending_d[i]) begin
        id_d = i[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      prev_q    <= '0;
      status_q  <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
    end else begin
      prev_q    <= intr_signal_i;
      status_q  <= status_d;
      pending_q <= pending_d;
      valid_q   <= |pending_d;
      id_q      <= id_d;
    end
  end

  generate
    if (OUT_MODE == 0) begin : g_level
      always_ff @(posedge clk) begin
        if (!reset_n_i) begin
          bus_q <= 1'b0;
        end else begin
          bus_q <= |pending_d;
        end
      end
    end else begin : g_pulse
      localparam int              CNT_W      = $clog2(PULSE_LEN + 1);
      localparam logic [CNT_W-1:0] PULSE_INIT = CNT_W'(PULSE_LEN);

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             new_evt;

      // A new event is a status bit newly set while enabled. Unmasking an
      // already-set bit, or re-setting a set bit, does not count.
      assign new_evt = |(pending_d & ~status_q);

      // Load on a new event (this also extends a running pulse). Otherwise
      // count down and saturate at zero.
      always_comb begin
        cnt_d = cnt_q;
        if (new_evt) begin
          cnt_d = PULSE_INIT;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // The line is registered from cnt_d, so it stays high exactly
      // PULSE_LEN cycles after the last new event.
      always_ff @(posedge clk) begin
        if (!reset_n_i) begin
          cnt_q <= '0;
          bus_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          bus_q <= (cnt_d != '0);
        end
      end
    end
  endgenerate

  assign intr_status_o  = status_q;
  assign intr_pending_o = pending_q;
  assign intr_valid_o   = valid_q;
  assign intr_id_o      = id_q;
  assign bus_intr_o     = bus_q;

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_intr_ctrl
// Purpose  : Directed self-checking bench for intr_ctrl. Three instances
//            share the same stimulus and differ only in output mode and
//            pulse length:
//              dut_a: pulse mode, PULSE_LEN=3
//              dut_b: level mode
//              dut_c: pulse mode, PULSE_LEN=4
//            All instances use EDGE_MASK=4'b0111, so source 3 is level.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sig, msk, clr, set_s;

  logic [3:0] st_a, pd_a, st_b, pd_b, st_c, pd_c;
  logic       vl_a, vl_b, vl_c, bus_a, bus_b, bus_c;
  logic [1:0] id_a, id_b, id_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  intr_ctrl #(.NUM_SRC(4), .EDGE_MASK(4'b0111), .OUT_MODE(1), .PULSE_LEN(3)) dut_a (
    .clk(clk), .reset_n_i(rst_n), .intr_signal_i(sig), .intr_mask_i(msk),
    .intr_clear_i(clr), .intr_set_i(set_s), .intr_status_o(st_a),
    .intr_pending_o(pd_a), .intr_valid_o(vl_a), .intr_id_o(id_a), .bus_intr_o(bus_a));

  intr_ctrl #(.NUM_SRC(4), .EDGE_MASK(4'b0111), .OUT_MODE(0), .PULSE_LEN(3)) dut_b (
    .clk(clk), .reset_n_i(rst_n), .intr_signal_i(sig), .intr_mask_i(msk),
    .intr_clear_i(clr), .intr_set_i(set_s), .intr_status_o(st_b),
    .intr_pending_o(pd_b), .intr_valid_o(vl_b), .intr_id_o(id_b), .bus_intr_o(bus_b));

  intr_ctrl #(.NUM_SRC(4), .EDGE_MASK(4'b0111), .OUT_MODE(1), .PULSE_LEN(4)) dut_c (
    .clk(clk), .reset_n_i(rst_n), .intr_signal_i(sig), .intr_mask_i(msk),
    .intr_clear_i(clr), .intr_set_i(set_s), .intr_status_o(st_c),
    .intr_pending_o(pd_c), .intr_valid_o(vl_c), .intr_id_o(id_c), .bus_intr_o(bus_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sig = '0; clr = '0; set_s = '0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sig = '0; msk = 4'hF; clr = '0; set_s = '0;
    #2;

    // 1. Reset with every input high: every output is held at 0.
    sig = 4'hF; msk = 4'hF; clr = 4'hF; set_s = 4'hF;
    step(); step();
    check("rst_status", 32'(st_a), 32'h0);
    check("rst_pending", 32'(pd_a), 32'h0);
    check("rst_valid", 32'(vl_a), 32'h0);
    check("rst_id", 32'(id_a), 32'h0);
    check("rst_bus_a", 32'(bus_a), 32'h0);
    check("rst_bus_b", 32'(bus_b), 32'h0);
    // Release with an edge source already high: prev was reset, so it counts.
    rst_n = 1'b1; sig = 4'b0001; clr = '0; set_s = '0;
    step();
    check("rel_status", 32'(st_a), 32'h1);
    check("rel_valid", 32'(vl_a), 32'h1);
    check("rel_bus_a", 32'(bus_a), 32'h1);

    // 2. Edge capture with bit 2 held high for 5 cycles (PULSE_LEN=3).
    do_reset();
    sig = 4'b0100;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("edge_bus_a_%0d", k), 32'(bus_a), (k <= 3) ? 32'h1 : 32'h0);
      check($sformatf("edge_bus_b_%0d", k), 32'(bus_b), 32'h1);
      check($sformatf("edge_status_%0d", k), 32'(st_a), 32'h4);
    end
    check("edge_id", 32'(id_a), 32'h2);
    check("edge_valid", 32'(vl_a), 32'h1);
    sig = '0;

    // 3. Clear versus event in the same cycle: the event wins.
    set_s = 4'b0010;
    step();
    check("cs_pre_status", 32'(st_a), 32'h6);
    set_s = '0; clr = 4'b0110; sig = 4'b0010;
    step();
    check("cs_status", 32'(st_a), 32'h2);
    check("cs_id", 32'(id_a), 32'h1);
    clr = 4'b0010; sig = '0;
    step();
    check("cs_cleared", 32'(st_a), 32'h0);
    check("cs_valid", 32'(vl_a), 32'h0);
    clr = '0;

    // 4. Masking: software set while masked, then unmask.
    do_reset();
    msk = 4'b0000; set_s = 4'b1000;
    step();
    check("msk_status", 32'(st_a), 32'h8);
    check("msk_pending", 32'(pd_a), 32'h0);
    check("msk_valid", 32'(vl_a), 32'h0);
    check("msk_bus_a", 32'(bus_a), 32'h0);
    check("msk_bus_b", 32'(bus_b), 32'h0);
    set_s = '0; msk = 4'b1000;
    step();
    check("unm_valid", 32'(vl_a), 32'h1);
    check("unm_id", 32'(id_a), 32'h3);
    check("unm_pending", 32'(pd_a), 32'h8);
    check("unm_bus_a", 32'(bus_a), 32'h0);
    check("unm_bus_b", 32'(bus_b), 32'h1);
    step();
    check("unm_bus_a_2", 32'(bus_a), 32'h0);

    // 5. Retrigger: bit 0 at t and bit 1 at t+2.
    //    dut_c (PULSE_LEN=4) is high t+1..t+6; dut_a (PULSE_LEN=3) is high t+1..t+5.
    do_reset();
    msk = 4'hF; sig = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("rt_bus_c_%0d", k), 32'(bus_c), (k <= 6) ? 32'h1 : 32'h0);
      check($sformatf("rt_bus_a_%0d", k), 32'(bus_a), (k <= 5) ? 32'h1 : 32'h0);
      check($sformatf("rt_id_%0d", k), 32'(id_c), 32'h0);
      if (k == 2) sig = 4'b0011;
    end
    check("rt_status", 32'(st_c), 32'h3);
    sig = '0;

    // 6. Level source 3 held high and cleared every cycle.
    do_reset();
    msk = 4'hF; sig = 4'b1000; clr = 4'b1000;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("lvl_status_%0d", k), 32'(st_a), 32'h8);
      check($sformatf("lvl_bus_a_%0d", k), 32'(bus_a), (k <= 3) ? 32'h1 : 32'h0);
      check($sformatf("lvl_bus_b_%0d", k), 32'(bus_b), 32'h1);
    end
    sig = '0;
    step();
    check("lvl_drop_status", 32'(st_a), 32'h0);
    check("lvl_drop_bus_b", 32'(bus_b), 32'h0);
    clr = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
